// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - single ROM port shared by download writes and three read requesters
module rom_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic [2:0]    RD_REQ,
    input  logic [AW-1:0] RD_ADDR0,
    input  logic [AW-1:0] RD_ADDR1,
    input  logic [AW-1:0] RD_ADDR2,
    output logic [2:0]    RD_ACK,
    output logic [DW-1:0] RD_DATA,
    input  logic          DL_ACTIVE,
    input  logic          DL_WR,
    input  logic [AW-1:0] DL_ADDR,
    input  logic [DW-1:0] DL_DATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_DIN,
    input  logic [DW-1:0] MEM_DOUT,
    output logic          BUSY,
    output logic          DL_OVF
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      lat_cnt;
    logic [1:0]      gnt_port;
    logic            rr_prefer2;
    logic            pend_valid;
    logic [AW-1:0]   pend_addr;
    logic [DW-1:0]   pend_data;

    logic            sel_valid;
    logic [1:0]      sel_port;
    logic [AW-1:0]   sel_addr;
    logic            do_write;
    logic            do_grant;
    logic            read_done;

    // Video always first; CPUs share by remembering who was served last.
    always_comb begin
        sel_valid = 1'b1;
        sel_port  = 2'd0;
        if (RD_REQ[0]) begin
            sel_port = 2'd0;
        end else if (RD_REQ[1] && RD_REQ[2]) begin
            sel_port = rr_prefer2 ? 2'd2 : 2'd1;
        end else if (RD_REQ[1]) begin
            sel_port = 2'd1;
        end else if (RD_REQ[2]) begin
            sel_port = 2'd2;
        end else begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        sel_addr = RD_ADDR0;
        case (sel_port)
            2'd1:    sel_addr = RD_ADDR1;
            2'd2:    sel_addr = RD_ADDR2;
            default: sel_addr = RD_ADDR0;
        endcase
    end

    assign do_write  = (state == IDLE) && pend_valid;
    assign do_grant  = (state == IDLE) && !pend_valid && !DL_ACTIVE && sel_valid;
    assign read_done = (lat_cnt == 3'(MEM_LAT - 1));
    assign BUSY      = (state != IDLE);

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (do_write) begin
                    state_nx = WRITE;
                end else if (do_grant) begin
                    state_nx = READ;
                end
            end
            WRITE:   state_nx = IDLE;
            READ:    state_nx = read_done ? DONE : READ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_ADDR   <= '0;
            MEM_DIN    <= '0;
            MEM_WE     <= 1'b0;
            RD_ACK     <= '0;
            RD_DATA    <= '0;
            DL_OVF     <= 1'b0;
            lat_cnt    <= '0;
            gnt_port   <= 2'd0;
            rr_prefer2 <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            MEM_WE <= 1'b0;
            RD_ACK <= '0;

            if (do_write) begin
                MEM_WE   <= 1'b1;
                MEM_ADDR <= pend_addr;
                MEM_DIN  <= pend_data;
            end else if (do_grant) begin
                MEM_ADDR <= sel_addr;
                lat_cnt  <= '0;
                gnt_port <= sel_port;
                if (sel_port == 2'd1) begin
                    rr_prefer2 <= 1'b1;
                end else if (sel_port == 2'd2) begin
                    rr_prefer2 <= 1'b0;
                end
            end

            if (state == READ) begin
                lat_cnt <= lat_cnt + 3'd1;
                if (read_done) begin
                    RD_DATA <= MEM_DOUT;
                    RD_ACK  <= 3'b001 << gnt_port;
                end
            end

            // The slot frees on the WRITE edge, so a strobe landing then refills it.
            if (DL_WR) begin
                if (!pend_valid || state == WRITE) begin
                    pend_valid <= 1'b1;
                    pend_addr  <= DL_ADDR;
                    pend_data  <= DL_DATA;
                end else begin
                    DL_OVF <= 1'b1;
                end
            end else if (state == WRITE) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one synchronous ROM/RAM port between the HPS ioctl download write stream and three read requesters: video tile fetch (port 0), main CPU (port 1) and sound CPU (port 2).
- Sits between the game core's ROM-address decoders and the single physical ROM memory.
- Download writes always win. Video has fixed top priority among readers. The two CPUs alternate round-robin.

Parameters:
- AW, 16, address width of all address ports.
- DW, 8, data width.
- MEM_LAT, 2, memory read latency in MCLK edges from MEM_ADDR change to valid MEM_DOUT; legal range 1..7.

Ports:
- MCLK  in  1  system clock (48 MHz domain).
- RESET_N  in  1  asynchronous active-low reset.
- RD_REQ  in  3  per-port read request, level; bit0 video, bit1 main CPU, bit2 sound CPU.
- RD_ADDR0/RD_ADDR1/RD_ADDR2  in  AW each  read address per port, held stable while that port's REQ is high.
- RD_ACK  out  3  one-cycle completion pulse per port.
- RD_DATA  out  DW  read data; valid in the cycle its RD_ACK bit is high, held until the next ACK.
- DL_ACTIVE  in  1  download in progress; reads are blocked while high.
- DL_WR  in  1  one-cycle download write strobe.
- DL_ADDR  in  AW  download write address.
- DL_DATA  in  DW  download write data.
- MEM_ADDR  out  AW  registered memory address.
- MEM_WE  out  1  registered memory write enable.
- MEM_DIN  out  DW  registered memory write data.
- MEM_DOUT  in  DW  memory read data.
- BUSY  out  1  high in any state other than IDLE.
- DL_OVF  out  1  sticky download-overflow flag; cleared only by reset.

Behaviour:
- Reset (async, RESET_N=0):
  - State IDLE.
  - MEM_ADDR=0, MEM_DIN=0, MEM_WE=0, RD_ACK=0, RD_DATA=0, BUSY=0, DL_OVF=0.
  - Write pending slot cleared.
  - Round-robin pointer set so port 1 wins the next CPU tie.
  - Reset mid-access abandons the access; no ACK is issued.
- Write capture:
  - DL_WR=1 loads {DL_ADDR,DL_DATA} into a one-entry pending slot.
  - If the slot is full and is not being drained on the same edge, the write is dropped and DL_OVF is set.
  - A strobe arriving on the same edge the slot drains is accepted.
- States:
  - IDLE:
    - Pending write present -> WRITE. This takes priority over any read, regardless of DL_ACTIVE.
    - Otherwise, if DL_ACTIVE=0 and any RD_REQ is set -> grant one port and go to READ. Grant order: port 0 first; otherwise the port 1/2 not served last. On a 1-vs-2 tie the pointer toggles after each CPU grant.
    - Otherwise stay in IDLE.
    - Grant edge: MEM_ADDR is loaded with the granted RD_ADDRn; the latency counter is cleared.
  - WRITE:
    - MEM_WE=1 with MEM_ADDR/MEM_DIN from the slot for exactly one cycle.
    - Slot cleared; next state IDLE.
  - READ:
    - Counter increments each edge.
    - When the counter reaches MEM_LAT-1, MEM_DOUT is sampled into RD_DATA on that edge and the granted RD_ACK bit is set -> DONE.
  - DONE:
    - RD_ACK is high for this one cycle; ACK is cleared on exit.
    - Next state IDLE.
    - REQ is not sampled for a new grant until IDLE.
- Latency:
  - Grant edge to RD_ACK high = MEM_LAT edges.
  - Read throughput is 1 per MEM_LAT+2 cycles.
  - Write occupancy is 2 cycles (IDLE+WRITE).
- Handshake:
  - A requester keeps REQ and ADDR stable until it sees ACK.
  - A REQ still high in the cycle after ACK is treated as a new request.
  - REQ dropped before ACK is a protocol error. The arbiter still completes the access and pulses ACK.
- DL_ACTIVE rising while in READ: the in-flight read completes normally. New grants are blocked until DL_ACTIVE=0.
- Starvation: continuous port-0 requests may starve ports 1/2. This is accepted because video fetch is bounded by the line timing.
- MEM_WE is never high in the same cycle as a read access.
- Addresses are passed unmodified; no wrap-around arithmetic.

Test Plan:
- Reset then a single read: MEM_LAT=2, RD_REQ=3'b010, RD_ADDR1=16'h1234, memory model returns 8'hA5 -> MEM_ADDR=1234 after the grant edge; RD_ACK=3'b010 for one cycle exactly 2 edges after the grant, with RD_DATA=A5.
- Priority and round-robin: RD_REQ=3'b111 held; each port re-requests after its ACK -> grant sequence 0,0,0… while port 0 holds REQ; with port 0 idle, the sequence alternates 1,2,1,2.
- Download priority: DL_ACTIVE=1, DL_WR pulses at addr 0..3 with data 10..13, every 4 cycles, RD_REQ=3'b001 -> four MEM_WE pulses with matching addr/data; no RD_ACK. After DL_ACTIVE=0, port 0 is ACKed.
- Overflow: DL_WR on 3 consecutive cycles while a read is in flight -> first write kept, second dropped, DL_OVF=1 and sticky; exactly one MEM_WE follows.
- Drain/accept coincidence: DL_WR on the same edge as WRITE -> both writes reach memory; DL_OVF stays 0.
- Async reset mid-read: RESET_N low during READ -> all outputs 0 immediately; no ACK after release; a new request after release completes with MEM_LAT latency.
